// File: rtl/data_ram.sv
// Byte-addressed little-endian data memory: combinational load port with
// sign/zero extension, synchronous store port (byte/half/word), synchronous
// clear. Multi-byte accesses may be unaligned and wrap past the top of memory.
module data_ram #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_ctrl,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [2:0]  rd_ctrl,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NUM_LANES = 4;

  typedef logic [ADDR_WIDTH-1:0] baddr_t;

  logic [7:0]                  mem_q [DEPTH];
  logic [NUM_LANES-1:0]        wr_be_d;
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] wr_ba_d;
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] rd_ba;
  logic [NUM_LANES-1:0][7:0]   rd_b;

  // Store decode: per-lane byte enables and wrapped byte addresses. Only the
  // three legal sizes with wr_en high produce enables; anything else (incl. X)
  // falls through to no write.
  always_comb begin
    wr_be_d = '0;
    if (wr_en) begin
      case (wr_ctrl)
        2'd0:    wr_be_d = 4'b1111;
        2'd1:    wr_be_d = 4'b0011;
        2'd2:    wr_be_d = 4'b0001;
        default: wr_be_d = 4'b0000;
      endcase
    end
    // Address arithmetic is done at ADDR_WIDTH bits so carries out of the
    // top byte wrap naturally to address 0.
    for (int k = 0; k < NUM_LANES; k++) begin
      wr_ba_d[k] = baddr_t'(wr_addr[ADDR_WIDTH-1:0] + baddr_t'(k));
    end
  end

  // Memory array: reset clears everything and wins over a same-cycle store.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (wr_be_d[k]) mem_q[wr_ba_d[k]] <= wr_data[8*k +: 8];
      end
    end
  end

  // Load byte fetch: four wrapped byte reads from the current contents.
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      rd_ba[k] = baddr_t'(rd_addr[ADDR_WIDTH-1:0] + baddr_t'(k));
      rd_b[k]  = mem_q[rd_ba[k]];
    end
  end

  // Load format: select width and extension; unused codes read as zero.
  always_comb begin
    rd_data = 32'h0;
    case (rd_ctrl)
      3'd1:    rd_data = rd_b;
      3'd2:    rd_data = {{16{rd_b[1][7]}}, rd_b[1], rd_b[0]};
      3'd3:    rd_data = {16'h0, rd_b[1], rd_b[0]};
      3'd4:    rd_data = {{24{rd_b[0][7]}}, rd_b[0]};
      3'd5:    rd_data = {24'h0, rd_b[0]};
      default: rd_data = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_data_ram.sv
// Scoreboard bench for data_ram: stimulus pushes expected load results, a
// negedge monitor pops and compares against rd_data.
module tb_data_ram;

  logic        clk = 1'b0;
  logic        rst, wr_en;
  logic [1:0]  wr_ctrl;
  logic [31:0] wr_addr, wr_data;
  logic [2:0]  rd_ctrl;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_vld = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  logic [7:0] ref_mem [4096];

  data_ram #(.ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ctrl(wr_ctrl),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_ctrl(rd_ctrl),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Reference load: gather bytes at (A+k) mod 4096, then extend.
  function automatic logic [31:0] ref_load(input logic [2:0] rc, input logic [31:0] ra);
    int a;
    logic [31:0] w;
    a = int'(ra % 32'd4096);
    w = {ref_mem[(a+3)%4096], ref_mem[(a+2)%4096], ref_mem[(a+1)%4096], ref_mem[a]};
    case (rc)
      3'd1: return w;
      3'd2: return (w[15] ? 32'hFFFF0000 : 32'h0) | (w & 32'hFFFF);
      3'd3: return w & 32'hFFFF;
      3'd4: return (w[7] ? 32'hFFFFFF00 : 32'h0) | (w & 32'hFF);
      3'd5: return w & 32'hFF;
      default: return 32'h0;
    endcase
  endfunction

  // One clock cycle of stimulus. Expected read uses pre-edge contents; the
  // model is then updated to post-edge contents.
  task automatic step(input logic r, input logic we, input logic [1:0] wc,
                      input logic [31:0] wa, input logic [31:0] wd,
                      input logic [2:0] rc, input logic [31:0] ra,
                      input bit chk, input bit use_c, input logic [31:0] cexp,
                      input string nm);
    int a, n;
    rst = r; wr_en = we; wr_ctrl = wc; wr_addr = wa; wr_data = wd;
    rd_ctrl = rc; rd_addr = ra;
    rd_vld = chk;
    if (chk) begin
      exp_q.push_back(use_c ? cexp : ref_load(rc, ra));
      name_q.push_back(nm);
    end
    if (r) begin
      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    end else if (we && wc != 2'd3) begin
      n = (wc == 2'd0) ? 4 : (wc == 2'd1) ? 2 : 1;
      a = int'(wa % 32'd4096);
      for (int k = 0; k < n; k++) ref_mem[(a+k)%4096] = wd[8*k +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] wc, input logic [31:0] wa, input logic [31:0] wd);
    step(1'b0, 1'b1, wc, wa, wd, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, "");
  endtask

  task automatic rdc(input logic [2:0] rc, input logic [31:0] ra, input logic [31:0] e, input string nm);
    step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, rc, ra, 1'b1, 1'b1, e, nm);
  endtask

  // Monitor: compare the combinational load result mid-cycle.
  always @(negedge clk) begin
    if (rd_vld) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underflow: read with no expected value, got %h", rd_data);
      end else begin
        logic [31:0] e;
        string nm;
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL %s: rd_addr=%h rd_ctrl=%0d got %h expected %h", nm, rd_addr, rd_ctrl, rd_data, e);
        end
      end
    end
  end

  initial begin
    // Reset, then zero sweeps
    step(1'b1, 1'b0, 2'd3, 32'h0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, "");
    for (int i = 0; i < 1024; i++) rdc(3'd1, i, 32'h0, "reset_sweep_lw");
    for (int i = 0; i < 1024; i++) rdc(3'd5, i, 32'h0, "reset_sweep_lbu");

    // Word store/load
    wr(2'd0, 32'h10, 32'h8765_4321);
    rdc(3'd1, 32'h10, 32'h87654321, "lw_10");
    rdc(3'd5, 32'h10, 32'h00000021, "lbu_10");
    rdc(3'd5, 32'h13, 32'h00000087, "lbu_13");
    rdc(3'd4, 32'h13, 32'hFFFFFF87, "lb_13");
    rdc(3'd2, 32'h12, 32'hFFFF8765, "lh_12");
    rdc(3'd3, 32'h12, 32'h00008765, "lhu_12");

    // Partial stores
    wr(2'd0, 32'h20, 32'h0);
    wr(2'd2, 32'h21, 32'hAAAA_AA5A);
    wr(2'd1, 32'h22, 32'h1234_BEEF);
    rdc(3'd1, 32'h20, 32'hBEEF5A00, "partial_lw_20");

    // Gating
    step(1'b0, 1'b0, 2'd0, 32'h10, 32'hFFFF_FFFF, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, "");
    rdc(3'd1, 32'h10, 32'h87654321, "gate_wr_en0");
    step(1'b0, 1'b1, 2'd3, 32'h10, 32'hFFFF_FFFF, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, "");
    rdc(3'd1, 32'h10, 32'h87654321, "gate_wr_ctrl3");
    rdc(3'd0, 32'h10, 32'h0, "rd_ctrl0");
    rdc(3'd6, 32'h10, 32'h0, "rd_ctrl6");
    rdc(3'd7, 32'h10, 32'h0, "rd_ctrl7");

    // Wrap and alias
    wr(2'd0, 32'hFFE, 32'hDEAD_BEEF);
    rdc(3'd5, 32'hFFE, 32'hEF, "wrap_ffe");
    rdc(3'd5, 32'hFFF, 32'hBE, "wrap_fff");
    rdc(3'd5, 32'h000, 32'hAD, "wrap_000");
    rdc(3'd5, 32'h001, 32'hDE, "wrap_001");
    rdc(3'd1, 32'h0000_1FFE, 32'hDEADBEEF, "alias_1ffe");

    // Read during write: old data before the edge, new after
    step(1'b0, 1'b1, 2'd0, 32'h10, 32'h1122_3344, 3'd1, 32'h10, 1'b1, 1'b1, 32'h87654321, "rdw_old");
    rdc(3'd1, 32'h10, 32'h11223344, "rdw_new");

    // Reset vs write collision
    step(1'b1, 1'b1, 2'd0, 32'h40, 32'h1, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, "");
    step(1'b0, 1'b1, 2'd0, 32'h40, 32'h55, 3'd1, 32'h40, 1'b1, 1'b1, 32'h0, "collide_lw_40");
    rdc(3'd1, 32'h40, 32'h55, "post_rst_write");
    rdc(3'd1, 32'h10, 32'h0, "rst_cleared_10");

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] wa, ra;
      wa = (($urandom_range(0, 3) == 0) ? 32'hFF8 + $urandom_range(0, 7) : $urandom_range(0, 31))
           | ($urandom_range(0, 1) ? {$urandom_range(0, 15), 12'h0} : 32'h0);
      ra = ($urandom_range(0, 3) == 0) ? 32'hFF8 + $urandom_range(0, 7) : $urandom_range(0, 31);
      step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           wa, $urandom, 3'($urandom_range(0, 7)), ra, 1'b1, 1'b0, 32'h0, "random");
    end

    rd_vld = 1'b0;
    for (int t = 0; t < 5 && exp_q.size() != 0; t++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected values left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_ram.md
# data_ram

Byte-addressed, little-endian data memory for the single-cycle CPU datapath. It serves the load/store stage with a combinational read port and a synchronous write port. Both ports support byte, halfword and word accesses; loads can be sign- or zero-extended. Contents are cleared by a synchronous reset.

## Interface
- `ADDR_WIDTH`, default 12: byte-address bits actually decoded; memory size is 2^ADDR_WIDTH bytes (4096).
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high; clears every byte to 0.
- `wr_en`, input, 1: write enable, sampled on the rising edge of `clk`.
- `wr_ctrl`, input, 2: store size. 0 = word (SW), 1 = halfword (SH), 2 = byte (SB), 3 = no write.
- `wr_addr`, input, 32: byte address of the store.
- `wr_data`, input, 32: store data; the low 8/16/32 bits are used according to `wr_ctrl`.
- `rd_ctrl`, input, 3: load type. 0 = none (output 0), 1 = LW, 2 = LH, 3 = LHU, 4 = LB, 5 = LBU, 6/7 = none (output 0).
- `rd_addr`, input, 32: byte address of the load.
- `rd_data`, output, 32: load result, combinational.

## Operation
- Storage is an array of 2^ADDR_WIDTH bytes.
- Address bits [31:ADDR_WIDTH] are ignored: the effective address is the address modulo 2^ADDR_WIDTH.
- Little-endian: byte k of a multi-byte access is at effective address (A+k) mod 2^ADDR_WIDTH.
- No alignment requirement. Unaligned halfword and word accesses are legal, and their bytes wrap past the top of memory to address 0.
- Read path:
  - LW: `rd_data` = {M[A+3], M[A+2], M[A+1], M[A]}.
  - LH: `rd_data` = {M[A+1], M[A]} sign-extended from bit 15. LHU zero-extends instead.
  - LB: `rd_data` = M[A] sign-extended from bit 7. LBU zero-extends instead.
  - `rd_ctrl` 0, 6 or 7: `rd_data` = 32'h0.
- Write path, on a rising edge with `wr_en`=1 and `rst`=0:
  - `wr_ctrl`=0: write `wr_data`[31:0] to bytes A..A+3.
  - `wr_ctrl`=1: write `wr_data`[15:0] to bytes A..A+1.
  - `wr_ctrl`=2: write `wr_data`[7:0] to byte A.
  - `wr_ctrl`=3: write nothing.
  - Bytes outside the selected size are never modified.
- `wr_en`=0: the memory is unchanged regardless of `wr_ctrl`.
- Reset: on a rising edge with `rst`=1, all bytes become 0. A write presented in the same cycle is discarded, because reset has priority.

## Timing
- Read latency is 0 cycles: `rd_data` is a pure combinational function of `rd_ctrl`, `rd_addr` and the current memory contents.
- Writes take effect at the rising edge and are visible on `rd_data` immediately after that edge.
- Read-during-write to an overlapping address: before the edge `rd_data` shows the old bytes; after the edge it shows the new bytes. There is no write-through forwarding within the cycle.
- After reset deasserts, every load from any address returns 0 until written. The output itself has no reset register; `rd_data` is 0 because the contents are 0.
- X or invalid control codes must never write memory. Only `wr_ctrl` values 0–2 together with `wr_en`=1 cause a write.

## Test plan
- Reset then sweep: assert `rst` for one edge, then set `rd_ctrl`=1 and step `rd_addr` from 0 to 1023. Required: `rd_data` = 0 at every step. Repeat with `rd_ctrl`=5.
- Word store/load: SW 32'h8765_4321 to address 0x10. Required: LW@0x10 = 32'h87654321; LBU@0x10 = 0x21; LBU@0x13 = 0x87; LB@0x13 = 32'hFFFFFF87; LH@0x12 = 32'hFFFF8765; LHU@0x12 = 32'h00008765.
- Partial stores: SW 0 to 0x20, then SB 32'hAAAA_AA5A to 0x21, then SH 32'h1234_BEEF to 0x22. Required: LW@0x20 = 32'hBEEF5A00.
- Gating: `wr_en`=0 with `wr_ctrl`=0, and separately `wr_en`=1 with `wr_ctrl`=3, each at 0x10. Required: LW@0x10 is unchanged. Also, `rd_ctrl`=0/6/7 → `rd_data` = 0.
- Wrap and alias: SW 32'hDEAD_BEEF to 0xFFE. Required: M[0xFFE] = 0xEF, M[0xFFF] = 0xBE, M[0x000] = 0xAD, M[0x001] = 0xDE. LW@0x0000_1FFE returns 32'hDEADBEEF.
- Reset vs write collision: assert `rst` and a SW 32'h1 to 0x40 in the same cycle. Required: LW@0x40 = 0. A write to 0x40 on the next edge with `rst`=0 is then stored.
